// File: rtl/hub75_framebuffer_driver_if.sv
// Pixel-write bus from the particle simulator into the HUB75 frame buffer.
// One pixel per cycle while write_en is high; there is no backpressure.
interface hub75_framebuffer_driver_if;
  logic        write_en;
  logic [5:0]  write_x;
  logic [5:0]  write_y;
  logic [11:0] pixel_color;

  modport master (output write_en, write_x, write_y, pixel_color);
  modport slave  (input  write_en, write_x, write_y, pixel_color);
endinterface

// File: rtl/hub75_framebuffer_driver.sv
// 64x64 frame buffer with a 1/32-scan HUB75 refresh engine using 4-bit binary-coded modulation.
// Every panel output is a flop loaded from the current state, so pins change one cycle after their state.
module hub75_framebuffer_driver #(
  parameter int BASE_TICKS = 32,
  parameter int DIM_W      = 6
) (
  input  logic                    clk,
  input  logic                    resetn,
  hub75_framebuffer_driver_if.slave wr,
  output logic                    hub_r1,
  output logic                    hub_g1,
  output logic                    hub_b1,
  output logic                    hub_r2,
  output logic                    hub_g2,
  output logic                    hub_b2,
  output logic [DIM_W-2:0]        hub_addr,
  output logic                    hub_sclk,
  output logic                    hub_lat,
  output logic                    hub_oe_n,
  output logic                    frame_done
);
  localparam int AW     = 2 * DIM_W;
  localparam int TICK_W = $clog2(BASE_TICKS * 8);

  typedef enum logic [1:0] {SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t             state_q, state_d;
  logic [DIM_W+1:0]   cnt_q, cnt_d;
  logic [DIM_W-2:0]   row_q, row_d;
  logic [1:0]         plane_q, plane_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [5:0]         rgb_q, rgb_d;
  logic [DIM_W-2:0]   addr_q, addr_d;
  logic               sclk_q, sclk_d;
  logic               lat_q, lat_d;
  logic               oe_n_q, oe_n_d;
  logic               done_q, done_d;
  logic [11:0]        top_q, top_d;

  logic [11:0]        mem [1<<AW];
  logic [11:0]        rdata_q;
  logic               rd_en;
  logic [AW-1:0]      raddr;

  logic [1:0]         ph;
  logic [DIM_W-1:0]   col;
  logic [TICK_W-1:0]  disp_last;

  function automatic logic [2:0] plane_bits(input logic [11:0] w, input logic [1:0] p);
    return {w[{2'd2, p}], w[{2'd1, p}], w[{2'd0, p}]};
  endfunction

  assign ph        = cnt_q[1:0];
  assign col       = cnt_q[DIM_W+1:2];
  assign disp_last = TICK_W'((BASE_TICKS << plane_q) - 1);

  // Column sub-sequence: ph0 reads the top half, ph1 the bottom half (row+32).
  assign rd_en = (state_q == SHIFT) && !ph[1];
  assign raddr = {ph[0], row_q, col};

  // Frame buffer: read-first, so a colliding write is seen on the next read.
  always_ff @(posedge clk) begin
    if (wr.write_en) mem[{wr.write_y, wr.write_x}] <= wr.pixel_color;
    if (rd_en) rdata_q <= mem[raddr];
    top_q <= top_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SHIFT;
      cnt_q   <= '0;
      row_q   <= '0;
      plane_q <= '0;
      tick_q  <= '0;
      rgb_q   <= '0;
      addr_q  <= '0;
      sclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      tick_q  <= tick_d;
      rgb_q   <= rgb_d;
      addr_q  <= addr_d;
      sclk_q  <= sclk_d;
      lat_q   <= lat_d;
      oe_n_q  <= oe_n_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    plane_d = plane_q;
    tick_d  = tick_q;
    rgb_d   = rgb_q;
    addr_d  = addr_q;
    top_d   = top_q;
    sclk_d  = 1'b0;
    lat_d   = 1'b0;
    oe_n_d  = 1'b1;
    done_d  = 1'b0;
    unique case (state_q)
      SHIFT: begin
        cnt_d  = cnt_q + 1'b1;
        sclk_d = (ph == 2'd3);
        if (ph == 2'd1) top_d = rdata_q;
        if (ph == 2'd2) rgb_d = {plane_bits(top_q, plane_q), plane_bits(rdata_q, plane_q)};
        if (cnt_q == '1) state_d = BLANK;
      end
      BLANK: state_d = LATCH;
      LATCH: begin
        lat_d   = 1'b1;
        addr_d  = row_q;
        tick_d  = '0;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        oe_n_d = 1'b0;
        tick_d = tick_q + 1'b1;
        if (tick_q == disp_last) begin
          // Last plane of a row pair advances the row; row 31 closes the frame.
          tick_d  = '0;
          state_d = SHIFT;
          plane_d = plane_q + 1'b1;
          if (plane_q == 2'd3) begin
            row_d  = row_q + 1'b1;
            done_d = (row_q == '1);
          end
        end
      end
      default: state_d = SHIFT;
    endcase
  end

  assign {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} = rgb_q;
  assign hub_addr   = addr_q;
  assign hub_sclk   = sclk_q;
  assign hub_lat    = lat_q;
  assign hub_oe_n   = oe_n_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_hub75_framebuffer_driver.sv
// Bench for hub75_framebuffer_driver: an absolute-cycle schedule model checked every cycle,
// plus hand-computed spot checks for timing, colour planes, read-first and mid-frame reset.
module tb_hub75_framebuffer_driver;
  localparam int BT     = 4;
  localparam int ROWLEN = 4 * 258 + 15 * BT;
  localparam int FRAME  = 32 * ROWLEN;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
  logic [4:0] hub_addr;
  logic hub_sclk, hub_lat, hub_oe_n, frame_done;

  hub75_framebuffer_driver_if wr_if();

  hub75_framebuffer_driver #(.BASE_TICKS(BT), .DIM_W(6)) dut (
    .clk(clk), .resetn(resetn), .wr(wr_if),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
    .hub_addr(hub_addr), .hub_sclk(hub_sclk), .hub_lat(hub_lat),
    .hub_oe_n(hub_oe_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int first_done = -1;
  int run_len = 0;
  int runs[$];

  logic [11:0] mem_m [4096];
  logic [11:0] top_s, bot_s;
  logic [5:0]  e_rgb;
  logic [4:0]  e_addr;
  logic        e_sclk, e_lat, e_oe_n, e_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
  endtask

  function automatic int seglen(input int p);
    return 258 + (BT << p);
  endfunction

  function automatic logic [11:0] bg(input int x, input int y);
    return 12'((x * 37 + y * 101 + 5) % 4096);
  endfunction

  function automatic logic [2:0] bits3(input logic [11:0] w, input int p);
    return {w[8 + p], w[4 + p], w[p]};
  endfunction

  // Reference schedule: place an absolute cycle within frame / row pair / plane / offset.
  task automatic decode(input int u, output int r, output int p, output int off);
    int v;
    v = u % FRAME;
    r = v / ROWLEN;
    v = v % ROWLEN;
    p = 0;
    while (v >= seglen(p)) begin
      v -= seglen(p);
      p++;
    end
    off = v;
  endtask

  // Model: what every panel pin must show in the cycle after state-cycle cyc.
  initial begin
    int r, p, off, c, ph;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        cyc = 0;
        e_rgb = '0; e_addr = '0; e_sclk = 1'b0; e_lat = 1'b0; e_oe_n = 1'b1; e_done = 1'b0;
      end else begin
        decode(cyc, r, p, off);
        c  = off / 4;
        ph = off % 4;
        e_sclk = 1'b0;
        if (off < 256) begin
          if (ph == 0) top_s = mem_m[r * 64 + c];
          if (ph == 1) bot_s = mem_m[(r + 32) * 64 + c];
          if (ph == 2) e_rgb = {bits3(top_s, p), bits3(bot_s, p)};
          e_sclk = (ph == 3);
        end
        e_lat  = (off == 257);
        e_oe_n = !(off >= 258);
        if (off == 257) e_addr = 5'(r);
        e_done = (p == 3) && (r == 31) && (off == seglen(3) - 1);
        cyc++;
      end
      if (wr_if.write_en) mem_m[{wr_if.write_y, wr_if.write_x}] = wr_if.pixel_color;
    end
  end

  // Compare process: every cycle, DUT pins against the model (or reset values).
  initial begin
    logic [14:0] dut_v, exp_v;
    forever begin
      @(negedge clk);
      dut_v = {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2, hub_addr, hub_sclk, hub_lat, hub_oe_n, frame_done};
      exp_v = {e_rgb, e_addr, e_sclk, e_lat, e_oe_n, e_done};
      if (!resetn) begin
        check("reset_outputs", 32'(dut_v), 32'h0002);
      end else begin
        check("model", 32'(dut_v), 32'(exp_v));
        check("lat_with_oe", 32'(hub_lat & ~hub_oe_n), 32'd0);
        if (frame_done && first_done < 0) first_done = cyc;
        if (!hub_oe_n) run_len++;
        else if (run_len > 0) begin
          runs.push_back(run_len);
          run_len = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wr_px(input int x, input int y, input logic [11:0] c);
    wr_if.write_en = 1'b1;
    wr_if.write_x = x[5:0];
    wr_if.write_y = y[5:0];
    wr_if.pixel_color = c;
    @(negedge clk);
    wr_if.write_en = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  localparam int S1 = 262, S2 = 528, S3 = 802;

  initial begin
    wr_if.write_en = 1'b0;
    wr_if.write_x = '0;
    wr_if.write_y = '0;
    wr_if.pixel_color = '0;
    repeat (2) @(negedge clk);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        wr_px(x, y, bg(x, y));
    wr_px(5, 0, 12'hF00);
    wr_px(5, 32, 12'h00F);
    wr_px(0, 1, 12'h500);
    wr_px(10, 0, 12'h000);
    check("rst_oe_n", 32'(hub_oe_n), 32'd1);
    check("rst_lat_sclk", 32'({hub_lat, hub_sclk, frame_done}), 32'd0);
    resetn = 1'b1;

    wait_cyc(3);  check("sclk_c3", 32'(hub_sclk), 32'd0);
    wait_cyc(4);  check("sclk_c4", 32'(hub_sclk), 32'd1);
    wait_cyc(24); check("col5_p0", 32'({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}), 32'b100001);
    wait_cyc(40);
    wr_px(10, 0, 12'h0F0);
    wait_cyc(44);  check("col10_old", 32'(hub_g1), 32'd0);
    wait_cyc(257); check("lat_c257", 32'(hub_lat), 32'd0);
    wait_cyc(258); check("lat_c258", 32'({hub_lat, hub_oe_n}), 32'b11);
    wait_cyc(259); check("oe_c259", 32'(hub_oe_n), 32'd0);
    wait_cyc(S1 + 24); check("col5_p1", 32'({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}), 32'b100001);
    wait_cyc(S1 + 44); check("col10_new", 32'(hub_g1), 32'd1);
    wait_cyc(S2 + 24); check("col5_p2", 32'({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}), 32'b100001);
    wait_cyc(S3 + 24); check("col5_p3", 32'({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}), 32'b100001);
    wait_cyc(ROWLEN + 4);
    check("r1_row1_p0", 32'(hub_r1), 32'd1);
    check("oe_runs_n", 32'(runs.size() >= 4), 32'd1);
    if (runs.size() >= 4) begin
      check("oe_run_p0", 32'(runs[0]), 32'd4);
      check("oe_run_p1", 32'(runs[1]), 32'd8);
      check("oe_run_p2", 32'(runs[2]), 32'd16);
      check("oe_run_p3", 32'(runs[3]), 32'd32);
    end
    wait_cyc(ROWLEN + S1 + 4); check("r1_row1_p1", 32'(hub_r1), 32'd0);
    wait_cyc(ROWLEN + S2 + 4); check("r1_row1_p2", 32'(hub_r1), 32'd1);
    wait_cyc(ROWLEN + S3 + 4); check("r1_row1_p3", 32'(hub_r1), 32'd0);

    wait_cyc(FRAME + 2);  check("frame_period", 32'(first_done), 32'd34944);
    wait_cyc(FRAME + 44); check("col10_frame2", 32'(hub_g1), 32'd1);

    wait_cyc(FRAME + 7 * ROWLEN + 260);
    check("row7_disp", 32'({hub_addr, hub_oe_n}), 32'({5'd7, 1'b0}));
    #2 resetn = 1'b0;
    #1 check("async_reset", 32'({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2, hub_addr, hub_sclk, hub_lat, hub_oe_n, frame_done}), 32'h0002);
    repeat (3) @(negedge clk);
    runs.delete();
    run_len = 0;
    resetn = 1'b1;
    wait_cyc(258); check("restart_lat", 32'({hub_lat, hub_addr}), 32'({1'b1, 5'd0}));
    wait_cyc(270);
    check("restart_runs_n", 32'(runs.size() >= 1), 32'd1);
    if (runs.size() >= 1) check("restart_plane0", 32'(runs[0]), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
